// File: rtl/pattern_packet_receiver.sv
// pattern_packet_receiver: parses A5-framed pattern packets from a byte stream, buffers accepted
// entries and replays them as paced write pulses. Define PATTERN_CHECKSUM_EN for 5-byte packets with XOR checksum.
module pattern_packet_receiver #(
   parameter int FIFO_DEPTH     = 8,
   parameter int TIMEOUT_CYCLES = 50000,
   parameter int WRITE_GAP      = 2
) (
   input  logic                        CLOCK50M,
   input  logic                        RESET_N,
   input  logic [7:0]                  byte_in,
   input  logic                        byte_valid,
   input  logic                        clear,
   output logic                        write,
   output logic [17:0]                 pattern_with_timestamp,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count,
   output logic                        overflow,
   output logic [7:0]                  err_count,
   output logic                        busy
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int GW = $clog2(WRITE_GAP + 1);
   localparam logic [TW-1:0] TIMER_LOAD = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [GW-1:0] GAP_LOAD   = GW'(WRITE_GAP - 1);
   localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);
   localparam logic [7:0]    HEADER     = 8'hA5;

   typedef enum logic [2:0] {S_IDLE, S_TS_HI, S_TS_LO, S_PAT, S_CSUM} state_t;

   state_t        state_reg;
   state_t        state_next;
   logic [TW-1:0] timer_reg;
   logic [9:0]    ts_reg;
`ifdef PATTERN_CHECKSUM_EN
   logic [7:0]    pat_reg;
   logic [7:0]    xor_reg;
`endif
   logic [9:0]    last_ts_reg;
   logic          last_valid_reg;

   logic [17:0]   mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_reg;
   logic [AW-1:0] rd_ptr_reg;
   logic [CW-1:0] count_reg;
   logic [GW-1:0] gap_reg;
   logic          write_reg;
   logic [17:0]   pwt_reg;
   logic          overflow_reg;
   logic [7:0]    err_reg;

   logic          take;
   logic          timeout_hit;
   logic          hdr_bad;
   logic          pkt_end;
   logic          csum_ok;
   logic          ts_ok;
   logic          fifo_full;
   logic          push;
   logic          pop;
   logic          ovf_evt;
   logic          err_evt;
   logic [17:0]   entry;

   // clear outranks a coincident byte, so the byte is never consumed
   assign take = byte_valid & ~clear;

   always_ff @(posedge CLOCK50M or negedge RESET_N) begin
      if (!RESET_N) begin
         state_reg <= S_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      timeout_hit = 1'b0;
      hdr_bad     = 1'b0;
      if (clear) begin
         state_next = S_IDLE;
      end else if (byte_valid) begin
         case (state_reg)
            S_IDLE:  if (byte_in == HEADER) state_next = S_TS_HI;
            S_TS_HI: begin
               if (byte_in[7:2] != 6'd0) begin
                  hdr_bad    = 1'b1;
                  state_next = S_IDLE;
               end else begin
                  state_next = S_TS_LO;
               end
            end
            S_TS_LO: state_next = S_PAT;
`ifdef PATTERN_CHECKSUM_EN
            S_PAT:   state_next = S_CSUM;
`else
            S_PAT:   state_next = S_IDLE;
`endif
            S_CSUM:  state_next = S_IDLE;
            default: state_next = S_IDLE;
         endcase
      end else if (state_reg != S_IDLE && timer_reg == '0) begin
         timeout_hit = 1'b1;
         state_next  = S_IDLE;
      end
   end

   always_comb begin
      ts_ok     = !last_valid_reg || (ts_reg > last_ts_reg);
      fifo_full = (count_reg == FULL_COUNT);
`ifdef PATTERN_CHECKSUM_EN
      pkt_end   = take && (state_reg == S_CSUM);
      csum_ok   = (byte_in == xor_reg);
      entry     = {ts_reg, pat_reg};
`else
      pkt_end   = take && (state_reg == S_PAT);
      csum_ok   = 1'b1;
      entry     = {ts_reg, byte_in};
`endif
      // fullness is judged on the pre-pop occupancy
      push      = pkt_end && csum_ok && ts_ok && !fifo_full;
      ovf_evt   = pkt_end && csum_ok && ts_ok && fifo_full;
      err_evt   = timeout_hit || hdr_bad || (pkt_end && !push);
      pop       = (count_reg != '0) && (gap_reg == '0) && !clear;
   end

   // Packet field capture and inter-byte idle timer
   always_ff @(posedge CLOCK50M or negedge RESET_N) begin
      if (!RESET_N) begin
         timer_reg <= '0;
         ts_reg    <= '0;
`ifdef PATTERN_CHECKSUM_EN
         pat_reg   <= '0;
         xor_reg   <= '0;
`endif
      end else begin
         if (byte_valid) begin
            timer_reg <= TIMER_LOAD;
         end else if (timer_reg != '0) begin
            timer_reg <= timer_reg - 1'b1;
         end
         if (take) begin
            case (state_reg)
               S_TS_HI: begin
                  ts_reg[9:8] <= byte_in[1:0];
`ifdef PATTERN_CHECKSUM_EN
                  xor_reg     <= byte_in;
`endif
               end
               S_TS_LO: begin
                  ts_reg[7:0] <= byte_in;
`ifdef PATTERN_CHECKSUM_EN
                  xor_reg     <= xor_reg ^ byte_in;
`endif
               end
`ifdef PATTERN_CHECKSUM_EN
               S_PAT: begin
                  pat_reg <= byte_in;
                  xor_reg <= xor_reg ^ byte_in;
               end
`endif
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge CLOCK50M) begin
      if (push) mem[wr_ptr_reg] <= entry;
   end

   always_ff @(posedge CLOCK50M or negedge RESET_N) begin
      if (!RESET_N) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else if (clear) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
         case ({push, pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: ;
         endcase
      end
   end

   // Paced replay: gap counter enforces WRITE_GAP cycles between pulses
   always_ff @(posedge CLOCK50M or negedge RESET_N) begin
      if (!RESET_N) begin
         write_reg <= 1'b0;
         pwt_reg   <= '0;
         gap_reg   <= '0;
      end else begin
         write_reg <= pop;
         if (pop) begin
            pwt_reg <= mem[rd_ptr_reg];
            gap_reg <= GAP_LOAD;
         end else if (gap_reg != '0) begin
            gap_reg <= gap_reg - 1'b1;
         end
      end
   end

   always_ff @(posedge CLOCK50M or negedge RESET_N) begin
      if (!RESET_N) begin
         overflow_reg   <= 1'b0;
         err_reg        <= '0;
         last_ts_reg    <= '0;
         last_valid_reg <= 1'b0;
      end else begin
         if (clear) begin
            overflow_reg   <= 1'b0;
            last_valid_reg <= 1'b0;
         end else begin
            if (ovf_evt) overflow_reg <= 1'b1;
            if (push) begin
               last_ts_reg    <= ts_reg;
               last_valid_reg <= 1'b1;
            end
         end
         if (err_evt && err_reg != 8'hFF) err_reg <= err_reg + 1'b1;
      end
   end

   assign write                  = write_reg;
   assign pattern_with_timestamp = pwt_reg;
   assign fifo_count             = count_reg;
   assign overflow               = overflow_reg;
   assign err_count              = err_reg;
   assign busy                   = (state_reg != S_IDLE);

endmodule
